// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: source indices, default widths and the broadcast
// bundle consumed by the RS and ROB.
package cdb_arbiter_pkg;

  localparam int CDB_N_SRC = 3;
  localparam int CDB_TAG_W = 5;
  localparam int CDB_XLEN  = 32;
  localparam int CDB_SRC_W = $clog2(CDB_N_SRC);

  localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [CDB_SRC_W-1:0] CDB_SRC_LB  = 2'd1;
  localparam logic [CDB_SRC_W-1:0] CDB_SRC_ACU = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  value;
    logic [CDB_SRC_W-1:0] src;
  } cdb_packet_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin find-first: rotate requests by ptr, pick lowest set bit,
// rotate the index back. Purely combinational.
module rr_priority_select #(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  k;
  logic [PW:0]    sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    k   = '0;
    any = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) begin
        k   = PW'(i);
        any = 1'b1;
      end
    end
    // k + ptr < 2N, so one conditional subtract is the modulo
    sum = {1'b0, k} + {1'b0, ptr};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx = sum[PW-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-port CDB arbiter: round-robin grant among result sources and a
// registered broadcast of the winner's tag/value to the RS and ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N_SRC = CDB_N_SRC,
  parameter  int TAG_W = CDB_TAG_W,
  parameter  int XLEN  = CDB_XLEN,
  localparam int SW    = $clog2(N_SRC)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [N_SRC-1:0]            src_valid,
  input  logic [N_SRC-1:0][TAG_W-1:0] src_tag,
  input  logic [N_SRC-1:0][XLEN-1:0]  src_value,
  output logic [N_SRC-1:0]            src_written,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic [SW-1:0]               cdb_src
);

  logic [SW-1:0]    rr_ptr;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] gnt;
  logic [SW-1:0]    gidx;
  logic             gany;
  logic [SW-1:0]    ptr_nxt;
  cdb_packet_t      pkt_q;

  // Grant never looks at tag/value, keeping wr_enable = ~valid | written acyclic
  assign req = src_valid & {N_SRC{~(flush | reset)}};

  rr_priority_select #(.N(N_SRC)) u_sel (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign src_written = gnt;
  assign ptr_nxt     = (gidx == SW'(N_SRC-1)) ? '0 : gidx + SW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      pkt_q  <= '0;
    end else begin
      pkt_q.valid <= gany;
      if (gany) begin
        pkt_q.tag   <= src_tag[gidx];
        pkt_q.value <= src_value[gidx];
        pkt_q.src   <= gidx;
        rr_ptr      <= ptr_nxt;
      end
    end
  end

  assign cdb_valid = pkt_q.valid;
  assign cdb_tag   = pkt_q.tag;
  assign cdb_value = pkt_q.value;
  assign cdb_src   = pkt_q.src;

endmodule
